// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window controller: FSM encoding
// and the coordinate-width helpers used by the top and the raster counter.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to hold a coordinate 0..n-1; never narrower than one bit.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IMG_W = 28;
  localparam int DEFAULT_IMG_H = 28;
  localparam int DEFAULT_COL_W = coord_w(DEFAULT_IMG_W);
  localparam int DEFAULT_ROW_W = coord_w(DEFAULT_IMG_H);

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/col position of the next pixel to be accepted.
// wrap flags the last column of a row, last flags the final pixel of the frame.
module raster_counter
  import conv_pkg::*;
#(
  parameter int IMG_W = DEFAULT_IMG_W,
  parameter int IMG_H = DEFAULT_IMG_H
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        advance,
  output logic [coord_w(IMG_H)-1:0]   row,
  output logic [coord_w(IMG_W)-1:0]   col,
  output logic                        wrap,
  output logic                        last
);

  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

  assign wrap = (col == COL_MAX);
  assign last = wrap && (row == ROW_MAX);

  // Step through the frame one accepted pixel at a time; clear restarts at the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (wrap) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Controller that feeds raster pixels into KxK line buffers and flags each
// complete window with its top-left coordinate, stalling input while a window
// is pending downstream.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = DEFAULT_IMG_W,
  parameter int IMG_H = DEFAULT_IMG_H,
  parameter int K     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            din,
  input  logic                        din_vld,
  output logic                        din_rdy,
  output logic                        lb_shift,
  output logic [WIDTH-1:0]            lb_din,
  output logic                        win_vld,
  input  logic                        win_rdy,
  output logic [coord_w(IMG_H)-1:0]   win_row,
  output logic [coord_w(IMG_W)-1:0]   win_col,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int RW  = coord_w(IMG_H);
  localparam int CW  = coord_w(IMG_W);
  localparam int KM1 = K - 1;

  if (K < 1 || K > IMG_W || K > IMG_H) begin : g_illegal_k
    $error("conv_window_ctrl: kernel size K=%0d does not fit a %0dx%0d frame", K, IMG_W, IMG_H);
  end

  state_t          state, state_next;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            col_wrap;
  logic            last_pixel;
  logic            accept;
  logic            qualify;
  logic            clear_pos;

  assign accept    = din_vld && din_rdy;
  assign lb_shift  = accept;
  assign lb_din    = din;
  assign clear_pos = (state == IDLE) && start;
  assign qualify   = (int'(row) >= KM1) && (int'(col) >= KM1);

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_pos),
    .advance (accept),
    .row     (row),
    .col     (col),
    .wrap    (col_wrap),
    .last    (last_pixel)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and state-derived outputs; the frame ends on acceptance of its last pixel.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    din_rdy    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = RUN;
      end
      RUN: begin
        din_rdy = !win_vld || win_rdy;
        if (accept && col_wrap && last_pixel) state_next = FLUSH;
      end
      FLUSH: begin
        if (!win_vld || win_rdy) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window flag and coordinates: a qualifying pixel loads a new window, consumption clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_vld <= 1'b0;
      win_row <= '0;
      win_col <= '0;
    end else if (accept && qualify) begin
      win_vld <= 1'b1;
      win_row <= row - RW'(KM1);
      win_col <= col - CW'(KM1);
    end else if (win_vld && win_rdy) begin
      win_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: default 28x28/K=3 instance plus a
// 4x4/K=1 instance, with a window-order monitor on the default instance.
module tb_conv_window_ctrl;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;
  logic       lb_shift;
  logic [7:0] lb_din;
  logic       win_vld;
  logic       win_rdy;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic       busy;
  logic       frame_done;

  logic       start_b;
  logic [7:0] din_b;
  logic       din_vld_b;
  logic       din_rdy_b;
  logic       lb_shift_b;
  logic [7:0] lb_din_b;
  logic       win_vld_b;
  logic       win_rdy_b;
  logic [1:0] win_row_b;
  logic [1:0] win_col_b;
  logic       busy_b;
  logic       frame_done_b;

  int total = 0;
  int bad   = 0;
  int win_count   = 0;
  int order_err   = 0;
  int done_count  = 0;
  logic [4:0] exp_r = '0;
  logic [4:0] exp_c = '0;

  always #5 clk = ~clk;

  conv_window_ctrl #(.WIDTH(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .lb_shift(lb_shift), .lb_din(lb_din), .win_vld(win_vld),
    .win_rdy(win_rdy), .win_row(win_row), .win_col(win_col), .busy(busy),
    .frame_done(frame_done)
  );

  conv_window_ctrl #(.WIDTH(8), .IMG_W(4), .IMG_H(4), .K(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b), .din_vld(din_vld_b),
    .din_rdy(din_rdy_b), .lb_shift(lb_shift_b), .lb_din(lb_din_b), .win_vld(win_vld_b),
    .win_rdy(win_rdy_b), .win_row(win_row_b), .win_col(win_col_b), .busy(busy_b),
    .frame_done(frame_done_b)
  );

  // Record every consumed window of the default instance and compare it to raster order.
  always @(negedge clk) begin
    if (start && !busy) begin
      win_count = 0;
      order_err = 0;
      exp_r     = '0;
      exp_c     = '0;
    end else if (win_vld && win_rdy) begin
      if (win_row !== exp_r || win_col !== exp_c) order_err++;
      win_count++;
      if (exp_c == 5'(IMG_W - K)) begin
        exp_c = '0;
        exp_r = exp_r + 5'd1;
      end else begin
        exp_c = exp_c + 5'd1;
      end
    end
    if (frame_done) done_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one pixel (optionally after a one-cycle gap) and hold it until accepted.
  task automatic apply_stimulus(input logic [7:0] v, input bit gap);
    logic acc;
    int   guard;
    if (gap) begin
      din_vld = 1'b0;
      @(posedge clk); #1;
    end
    din     = v;
    din_vld = 1'b1;
    acc     = 1'b0;
    guard   = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = din_rdy;
      @(posedge clk); #1;
      guard++;
    end
    din_vld = 1'b0;
    if (!acc) check_output("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0; din_vld = 1'b1; win_rdy = 1'b1;
    start_b = 1'b0; din_b = '0; din_vld_b = 1'b0; win_rdy_b = 1'b1;
    #2 rst = 1'b0;
    #10;
    $display("[TB] reset state");
    check_output("rst_busy",       32'(busy),       32'd0);
    check_output("rst_din_rdy",    32'(din_rdy),    32'd0);
    check_output("rst_lb_shift",   32'(lb_shift),   32'd0);
    check_output("rst_win_vld",    32'(win_vld),    32'd0);
    check_output("rst_win_row",    32'(win_row),    32'd0);
    check_output("rst_win_col",    32'(win_col),    32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("idle_lb_shift", 32'(lb_shift), 32'd0);
    check_output("idle_din_rdy",  32'(din_rdy),  32'd0);
    din_vld = 1'b0;

    $display("[TB] frame 1: back-to-back, start ignored mid-frame");
    pulse_start();
    check_output("run_busy",    32'(busy),    32'd1);
    check_output("run_din_rdy", 32'(din_rdy), 32'd1);
    for (int i = 0; i < NPIX; i++) begin
      if (i == 5) begin
        din = 8'hA5; din_vld = 1'b1;
        #1;
        check_output("pass_lb_shift", 32'(lb_shift), 32'd1);
        check_output("pass_lb_din",   32'(lb_din),   32'hA5);
      end
      if (i == 100) start = 1'b1;
      apply_stimulus(8'(i), 1'b0);
      start = 1'b0;
      if (i == 57) check_output("fill_no_win", 32'(win_vld), 32'd0);
      if (i == 58) begin
        check_output("first_win_vld", 32'(win_vld), 32'd1);
        check_output("first_win_row", 32'(win_row), 32'd0);
        check_output("first_win_col", 32'(win_col), 32'd0);
      end
    end
    check_output("flush_busy",    32'(busy),    32'd1);
    check_output("flush_din_rdy", 32'(din_rdy), 32'd0);
    check_output("last_win_vld",  32'(win_vld), 32'd1);
    check_output("last_win_row",  32'(win_row), 32'd25);
    check_output("last_win_col",  32'(win_col), 32'd25);
    din_vld = 1'b1;
    #1;
    check_output("flush_lb_shift", 32'(lb_shift), 32'd0);
    @(posedge clk); #1;
    din_vld = 1'b0;
    check_output("done_pulse", 32'(frame_done), 32'd1);
    @(posedge clk); #1;
    check_output("done_cleared", 32'(frame_done), 32'd0);
    check_output("back_idle",    32'(busy),       32'd0);
    check_output("f1_win_count", 32'(win_count),  32'd676);
    check_output("f1_order",     32'(order_err),  32'd0);
    check_output("f1_done_cnt",  32'(done_count), 32'd1);

    $display("[TB] frame 2: random gaps and a 5-cycle downstream stall at (4,7)");
    pulse_start();
    for (int i = 0; i < NPIX; i++) begin
      apply_stimulus(8'(i), bit'($urandom_range(0, 1)));
      if (i == 6 * IMG_W + 9) begin
        check_output("stall_win_vld", 32'(win_vld), 32'd1);
        win_rdy = 1'b0;
        din     = 8'h3C;
        din_vld = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check_output("stall_din_rdy",  32'(din_rdy),  32'd0);
          check_output("stall_lb_shift", 32'(lb_shift), 32'd0);
          check_output("stall_win_row",  32'(win_row),  32'd4);
          check_output("stall_win_col",  32'(win_col),  32'd7);
        end
        @(posedge clk); #1;
        win_rdy = 1'b1;
        din_vld = 1'b0;
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("f2_idle",      32'(busy),       32'd0);
    check_output("f2_win_count", 32'(win_count),  32'd676);
    check_output("f2_order",     32'(order_err),  32'd0);
    check_output("f2_done_cnt",  32'(done_count), 32'd2);

    $display("[TB] frame 3: reset at pixel (10,3), then restart");
    pulse_start();
    for (int i = 0; i <= 10 * IMG_W + 3; i++) apply_stimulus(8'(i), 1'b0);
    check_output("pre_rst_win_vld", 32'(win_vld), 32'd1);
    rst = 1'b0;
    #1;
    check_output("mid_rst_busy",    32'(busy),    32'd0);
    check_output("mid_rst_win_vld", 32'(win_vld), 32'd0);
    check_output("mid_rst_din_rdy", 32'(din_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("rst_no_done", 32'(done_count), 32'd2);
    check_output("rst_idle",    32'(busy),       32'd0);
    pulse_start();
    for (int i = 0; i <= 2 * IMG_W + 2; i++) begin
      apply_stimulus(8'(i), 1'b0);
      if (i == 2 * IMG_W + 1) check_output("re_fill_no_win", 32'(win_vld), 32'd0);
    end
    check_output("re_first_vld", 32'(win_vld), 32'd1);
    check_output("re_first_row", 32'(win_row), 32'd0);
    check_output("re_first_col", 32'(win_col), 32'd0);

    $display("[TB] K=1 on a 4x4 frame");
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check_output("b_busy",    32'(busy_b),    32'd1);
    check_output("b_din_rdy", 32'(din_rdy_b), 32'd1);
    din_vld_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_b = 8'(i);
      @(posedge clk); #1;
      check_output("b_win_vld", 32'(win_vld_b), 32'd1);
      check_output("b_win_row", 32'(win_row_b), 32'(i / 4));
      check_output("b_win_col", 32'(win_col_b), 32'(i % 4));
    end
    din_vld_b = 1'b0;
    @(posedge clk); #1;
    check_output("b_done", 32'(frame_done_b), 32'd1);
    @(posedge clk); #1;
    check_output("b_idle", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
